// File: rtl/str_fifo.sv
// str_fifo: synchronous valid/ready stream FIFO.
// Decouples producer and consumer handshakes, stores up to DEPTH words in
// order, and registers both s_tready and m_tvalid so neither handshake sees a
// combinational path through the FIFO.
// Optional build macro STR_FIFO_LEVEL_EN adds the `level` occupancy output.
module str_fifo #(
    parameter int VW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_tvalid,
    output logic                     s_tready,
    input  logic [VW-1:0]            s_tdata,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [VW-1:0]            m_tdata
`ifdef STR_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    // Pointers carry one extra wrap bit; the low AW bits index storage.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   cnt;
    logic [AW:0]   cnt_next;
    logic [VW-1:0] mem [DEPTH];
    logic          wr_en;
    logic          rd_en;

    // A transfer only happens when both sides of that handshake agree; the
    // ready/valid flags are registered so full/empty collisions resolve here.
    assign wr_en = s_tvalid && s_tready;
    assign rd_en = m_tvalid && m_tready;

    // Occupancy after this edge: simultaneous read and write cancel out.
    always_comb begin
        cnt_next = cnt;
        if (wr_en && !rd_en) begin
            cnt_next = cnt + 1'b1;
        end else if (rd_en && !wr_en) begin
            cnt_next = cnt - 1'b1;
        end
    end

    // Pointers, occupancy and registered handshake flags; reset wins over
    // any handshake sampled in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            s_tready <= 1'b1;
            m_tvalid <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt      <= cnt_next;
            s_tready <= (cnt_next != FULL_CNT);
            m_tvalid <= (cnt_next != '0);
        end
    end

    // Storage array; cleared on reset so the head word reads as zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= s_tdata;
        end
    end

    assign m_tdata = mem[rd_ptr[AW-1:0]];

`ifdef STR_FIFO_LEVEL_EN
    assign level = cnt;
`endif

endmodule

// File: tb/tb_str_fifo.sv
// tb_str_fifo: directed plus randomized bench for str_fifo.
// A queue holds the words the FIFO should contain; every cycle the DUT's
// handshake flags, head word and (when STR_FIFO_LEVEL_EN is defined) level
// are compared against it.
module tb_str_fifo;

    localparam int VW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_tvalid = 1'b0;
    logic          s_tready;
    logic [VW-1:0] s_tdata = '0;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic [VW-1:0] m_tdata;
`ifdef STR_FIFO_LEVEL_EN
    logic [$clog2(DEPTH):0] level;
`endif

    int checks   = 0;
    int failures = 0;

    logic [VW-1:0] model_q[$];
    logic [VW-1:0] out_q[$];
    bit            last_wr;
    bit            last_rd;

    str_fifo #(.VW(VW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata)
`ifdef STR_FIFO_LEVEL_EN
        ,
        .level    (level)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: decide transfers from the model's occupancy, advance the
    // model, then compare the DUT against it.
    task automatic cycle(input string tag);
        bit wr;
        bit rd;
        wr = !rst && s_tvalid && (model_q.size() < DEPTH);
        rd = !rst && m_tready && (model_q.size() > 0);
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
        end else begin
            if (rd) out_q.push_back(model_q.pop_front());
            if (wr) model_q.push_back(s_tdata);
        end
        last_wr = wr;
        last_rd = rd;
        chk({tag, ".s_tready"}, 32'(s_tready), 32'(model_q.size() != DEPTH));
        chk({tag, ".m_tvalid"}, 32'(m_tvalid), 32'(model_q.size() != 0));
        if (model_q.size() != 0) chk({tag, ".m_tdata"}, m_tdata, model_q[0]);
`ifdef STR_FIFO_LEVEL_EN
        chk({tag, ".level"}, 32'(level), 32'(model_q.size()));
`endif
    endtask

    initial begin
        int written;
        int base;
        bit stall;
        logic [VW-1:0] held;

        // Reset, then idle
        rst = 1'b1;
        cycle("reset");
        cycle("reset");
        chk("reset.m_tdata", m_tdata, 32'h0);
        rst = 1'b0;
        cycle("idle");
        chk("idle.s_tready", 32'(s_tready), 32'd1);
        chk("idle.m_tvalid", 32'(m_tvalid), 32'd0);

        // Single word with consumer ready
        s_tvalid = 1'b1; s_tdata = 32'hDEADBEEF; m_tready = 1'b1;
        cycle("single_wr");
        chk("single.data", m_tdata, 32'hDEADBEEF);
        s_tvalid = 1'b0;
        cycle("single_rd");
        chk("single.empty", 32'(m_tvalid), 32'd0);
        chk("single.out", out_q.pop_front(), 32'hDEADBEEF);
        out_q.delete();

        // Fill with 1..8 while the consumer stalls
        m_tready = 1'b0;
        for (int i = 1; i <= DEPTH; i++) begin
            s_tvalid = 1'b1; s_tdata = VW'(i);
            cycle("fill");
        end
        chk("full.s_tready", 32'(s_tready), 32'd0);
        s_tdata = 32'd9;
        cycle("holdoff");
        chk("holdoff.no_store", 32'(last_wr), 32'd0);

        // Full with both handshakes active: only the read happens
        m_tready = 1'b1;
        cycle("full_simul");
        chk("full_simul.rd", 32'(last_rd), 32'd1);
        chk("full_simul.wr", 32'(last_wr), 32'd0);
        chk("full_simul.s_tready", 32'(s_tready), 32'd1);
        cycle("write9");
        chk("write9.wr", 32'(last_wr), 32'd1);
        s_tvalid = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) cycle("drain");
        chk("drain.count", 32'(out_q.size()), 32'd9);
        for (int i = 1; i <= 9 && out_q.size() > 0; i++) begin
            chk("drain.order", out_q.pop_front(), VW'(i));
        end
        out_q.delete();

        // Random streaming with wrap-around
        written = 0;
        base = 32'h1000;
        for (int c = 0; c < 3000 && written < 100; c++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = VW'(base + written);
            stall = m_tvalid && !m_tready;
            held  = m_tdata;
            cycle("rand");
            if (stall) begin
                chk("rand.stall_valid", 32'(m_tvalid), 32'd1);
                chk("rand.stall_data", m_tdata, held);
            end
            if (last_wr) written++;
        end
        chk("rand.written", 32'(written), 32'd100);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cycle("rand_drain");
        chk("rand.count", 32'(out_q.size()), 32'd100);
        chk("rand.wraps", 32'(written / DEPTH >= 6), 32'd1);
        for (int i = 0; i < 100 && out_q.size() > 0; i++) begin
            chk("rand.order", out_q.pop_front(), VW'(base + i));
        end
        out_q.delete();

        // Reset mid-stream with 5 words stored
        m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 1'b1; s_tdata = VW'(32'h500 + i);
            cycle("pre_rst");
        end
        rst = 1'b1; s_tvalid = 1'b1; m_tready = 1'b1;
        cycle("mid_rst");
        chk("mid_rst.m_tvalid", 32'(m_tvalid), 32'd0);
        chk("mid_rst.s_tready", 32'(s_tready), 32'd1);
        rst = 1'b0; s_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) cycle("post_rst");
        chk("post_rst.delivered", 32'(out_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/str_fifo.md
# str_fifo

Synchronous valid/ready stream FIFO between a stream producer (`str_src` side) and a stream consumer (`str_drn` side). It decouples the two handshakes, absorbs back-pressure bursts up to `DEPTH` words and preserves word order. There is no combinational path from `m_tready` to `s_tready` or from `s_tvalid` to `m_tvalid`, so it can break long handshake paths in the stream fabric.

## Interface
- `VW`, 32, data word width in bits (≥1)
- `DEPTH`, 8, storage words; power of two, ≥2

- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_tvalid`  in  1  upstream word valid
- `s_tready`  out  1  FIFO can accept a word
- `s_tdata`  in  VW  upstream word
- `m_tvalid`  out  1  FIFO holds a word for downstream
- `m_tready`  in  1  downstream accepts the word
- `m_tdata`  out  VW  head-of-FIFO word
- `level`  out  $clog2(DEPTH)+1  occupancy 0..DEPTH (only with `STR_FIFO_LEVEL_EN`)

## Operation
- Write transfer: `s_tvalid && s_tready` at a rising edge. Stores `s_tdata` at the write pointer and advances it.
- Read transfer: `m_tvalid && m_tready` at a rising edge. Advances the read pointer.
- Pointers are $clog2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH. The index is the low bits.
  - empty: pointers are equal.
  - full: index bits are equal and the MSBs differ.
- Occupancy register `cnt` updates as follows:
  - write only: +1
  - read only: −1
  - both or neither: unchanged
  - It never exceeds DEPTH and never underflows.
- `s_tready` is registered and equals `cnt_next != DEPTH`.
- `m_tvalid` is registered and equals `cnt_next != 0`.
- `m_tdata` is the storage word at the read index.
- Simultaneous read and write:
  - When not empty and not full, both occur. `cnt` is unchanged and both pointers advance.
  - When full, only the read occurs, because `s_tready` = 0. `s_tready` rises the next cycle.
  - When empty, only the write occurs, because `m_tvalid` = 0. There is no fall-through.
- Stream rule: while `m_tvalid && !m_tready`, `m_tvalid` and `m_tdata` stay stable.
- Upstream words offered while `s_tready` = 0 are not stored. Holding them is upstream's responsibility.

## Timing
- Reset values:
  - `s_tready` = 1
  - `m_tvalid` = 0
  - `m_tdata` = 0 (storage cleared)
  - pointers = 0
  - `cnt` / `level` = 0
- Reset mid-operation:
  - All contents are discarded.
  - Handshakes sampled in a cycle with `rst` = 1 are ignored.
  - The state after the edge is the reset state.
- Latency: a word written at edge k appears with `m_tvalid` = 1 after edge k. It can be read at edge k+1 at the earliest.
- Throughput: one word per cycle sustained when `m_tready` = 1 and not empty.
- Full to not-full: read at edge k gives `s_tready` = 1 after edge k. A new write can occur at edge k+1.

## Configuration
- `STR_FIFO_LEVEL_EN` defined:
  - Port `level` exists and is driven from the registered `cnt`.
  - It updates at the same edge as the transfers, with reset value 0.
- `STR_FIFO_LEVEL_EN` undefined:
  - Port `level` is absent.
  - `cnt` stays internal only.
  - Handshake behaviour is identical in both builds.

## Test plan
- Reset, then idle:
  - `s_tready` = 1 and `m_tvalid` = 0 at the first edge after `rst` falls.
  - `level` = 0.
- Single word, VW=32: write 0xDEADBEEF at edge 1 with `m_tready` = 1.
  - `m_tvalid` = 1 and `m_tdata` = 0xDEADBEEF after edge 1.
  - Read at edge 2; `m_tvalid` = 0 after edge 2.
- Fill and drain, DEPTH=8: `m_tready` = 0, write 1..8.
  - `s_tready` = 0 after the 8th write and `level` = 8.
  - A 9th word (9) is held off by the source.
  - Raise `m_tready`; the output order is 1..9.
- Full simultaneous: FIFO full, `s_tvalid` = 1 and `m_tready` = 1 for one edge.
  - Exactly one read and no write.
  - `level` goes from 8 to 7.
  - `s_tready` = 1 the next cycle.
- Streaming plus wrap: 100 random words with random `s_tvalid` / `m_tready` (50%).
  - Data is in order with no loss and no duplication.
  - Pointers wrap at least 6 times.
  - Output is stable under stall.
- Reset mid-stream: FIFO holds 5 words; assert `rst` for one cycle with `s_tvalid` = `m_tready` = 1.
  - Afterwards `m_tvalid` = 0, `level` = 0, `s_tready` = 1.
  - No word is delivered.
